// File: rtl/up_down_count_decoder.sv
// Monitor/decoder for an up/down counter's count bus: classifies each sample as hold, step, wrap or illegal jump
// and extends the count into a wider position. Optional build macro: STICKY_ERR_EN (err latches until reset).
module up_down_count_decoder #(
  parameter int WIDTH     = 4,
  parameter int EXT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_count,
  output logic                 dir,
  output logic                 step,
  output logic                 dir_change,
  output logic                 wrap_up,
  output logic                 wrap_down,
  output logic                 err,
  output logic [EXT_WIDTH-1:0] pos
);

  generate
    if (WIDTH < 2 || WIDTH > 8) begin : g_bad_width
      $error("up_down_count_decoder: WIDTH must be in 2..8");
    end
    if (EXT_WIDTH <= WIDTH) begin : g_bad_ext_width
      $error("up_down_count_decoder: EXT_WIDTH must exceed WIDTH");
    end
  endgenerate

  typedef enum logic [2:0] {
    SYNC,
    HOLD,
    UP,
    DOWN,
    ERR
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ALL_ZERO = '0;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_t                 state, state_nxt;
  logic [WIDTH-1:0]       prev, prev_nxt;
  logic [WIDTH-1:0]       delta;
  logic [EXT_WIDTH-1:0]   pos_nxt;
  logic                   dir_nxt;
  logic                   step_nxt;
  logic                   dir_change_nxt;
  logic                   wrap_up_nxt;
  logic                   wrap_down_nxt;
  logic                   err_nxt;

  assign delta = in_count - prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SYNC;
      prev       <= '0;
      pos        <= '0;
      dir        <= 1'b1;
      step       <= 1'b0;
      dir_change <= 1'b0;
      wrap_up    <= 1'b0;
      wrap_down  <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev       <= prev_nxt;
      pos        <= pos_nxt;
      dir        <= dir_nxt;
      step       <= step_nxt;
      dir_change <= dir_change_nxt;
      wrap_up    <= wrap_up_nxt;
      wrap_down  <= wrap_down_nxt;
      err        <= err_nxt;
    end
  end

  // Every non-SYNC state decodes identically; state only remembers the last classification.
  always_comb begin
    state_nxt      = state;
    prev_nxt       = in_count;
    pos_nxt        = pos;
    dir_nxt        = dir;
    step_nxt       = 1'b0;
    dir_change_nxt = 1'b0;
    wrap_up_nxt    = 1'b0;
    wrap_down_nxt  = 1'b0;
`ifdef STICKY_ERR_EN
    err_nxt        = err;
`else
    err_nxt        = 1'b0;
`endif

    if (state == SYNC) begin
      pos_nxt   = {{(EXT_WIDTH-WIDTH){1'b0}}, in_count};
      state_nxt = HOLD;
    end else if (delta == ALL_ZERO) begin
      state_nxt = HOLD;
    end else if (delta == ONE) begin
      state_nxt      = UP;
      step_nxt       = 1'b1;
      pos_nxt        = pos + EXT_WIDTH'(1);
      dir_nxt        = 1'b1;
      dir_change_nxt = ~dir;
      wrap_up_nxt    = (prev == ALL_ONES);
    end else if (delta == ALL_ONES) begin
      state_nxt      = DOWN;
      step_nxt       = 1'b1;
      pos_nxt        = pos - EXT_WIDTH'(1);
      dir_nxt        = 1'b0;
      dir_change_nxt = dir;
      wrap_down_nxt  = (prev == ALL_ZERO);
    end else begin
      // Illegal jump: resynchronise the low bits to the bus, keep the extension bits.
      state_nxt = ERR;
      err_nxt   = 1'b1;
      pos_nxt   = {pos[EXT_WIDTH-1:WIDTH], in_count};
    end
  end

endmodule

// File: tb/tb_up_down_count_decoder.sv
// Scoreboard bench for up_down_count_decoder: directed count sequences push expected outputs,
// a monitor pops and compares one entry per clock after each sampling edge.
module tb_up_down_count_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] in_count = 4'd0;
  logic       dir, step, dir_change, wrap_up, wrap_down, err;
  logic [7:0] pos;

  typedef struct packed {
    logic       dir;
    logic       step;
    logic       dir_change;
    logic       wrap_up;
    logic       wrap_down;
    logic       err;
    logic [7:0] pos;
  } exp_t;

`ifdef STICKY_ERR_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad = 0;
  exp_t  actual;

  assign actual = {dir, step, dir_change, wrap_up, wrap_down, err, pos};

  up_down_count_decoder #(.WIDTH(4), .EXT_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_count   (in_count),
    .dir        (dir),
    .step       (step),
    .dir_change (dir_change),
    .wrap_up    (wrap_up),
    .wrap_down  (wrap_down),
    .err        (err),
    .pos        (pos)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic d, input logic s, input logic dc, input logic wu,
                              input logic wd, input logic e, input logic [7:0] p);
    mk = {d, s, dc, wu, wd, e, p};
  endfunction

  task automatic checkOutput(input string nm, input exp_t e, input exp_t a);
    total++;
    if (a !== e) begin
      bad++;
      $display("[TB] FAIL %s: got dir=%0b step=%0b dchg=%0b wup=%0b wdn=%0b err=%0b pos=%0d, want dir=%0b step=%0b dchg=%0b wup=%0b wdn=%0b err=%0b pos=%0d",
               nm, a.dir, a.step, a.dir_change, a.wrap_up, a.wrap_down, a.err, a.pos,
               e.dir, e.step, e.dir_change, e.wrap_up, e.wrap_down, e.err, e.pos);
    end
  endtask

  // Monitor: the decoder presents a fresh classification after every edge out of reset.
  always @(posedge clk) begin
    #1;
    if (!reset && exp_q.size() > 0) begin
      checkOutput(name_q.pop_front(), exp_q.pop_front(), actual);
    end
  end

  task automatic applyStimulus(input logic [3:0] v, input exp_t e, input string nm);
    @(negedge clk);
    in_count = v;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
  endtask

  // Asserts reset away from any edge, checks async clear and hold, then releases into a SYNC edge.
  task automatic doReset(input logic [3:0] v, input string nm);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 checkOutput({nm, "_async_clear"}, mk(1, 0, 0, 0, 0, 0, 8'd0), actual);
    @(negedge clk);
    checkOutput({nm, "_held"}, mk(1, 0, 0, 0, 0, 0, 8'd0), actual);
    in_count = v;
    reset = 1'b0;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, {4'd0, v}));
    name_q.push_back({nm, "_sync"});
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] start, sticky=%0b", STICKY);

    // Full up count with wrap, then an illegal jump from pos 16 and recovery.
    doReset(4'd0, "t1");
    for (int i = 1; i <= 15; i++)
      applyStimulus(4'(i), mk(1, 1, 0, 0, 0, 0, 8'(i)), $sformatf("t1_up_%0d", i));
    applyStimulus(4'd0, mk(1, 1, 0, 1, 0, 0, 8'd16), "t1_wrap_up");
    applyStimulus(4'd5, mk(1, 0, 0, 0, 0, 1, 8'd21), "t1_jump_upper_kept");
    applyStimulus(4'd4, mk(0, 1, 1, 0, 0, STICKY, 8'd20), "t1_after_err_down");

    // Up then reversal down.
    doReset(4'd0, "t2");
    for (int i = 1; i <= 5; i++)
      applyStimulus(4'(i), mk(1, 1, 0, 0, 0, 0, 8'(i)), $sformatf("t2_up_%0d", i));
    applyStimulus(4'd4, mk(0, 1, 1, 0, 0, 0, 8'd4), "t2_reverse");
    applyStimulus(4'd3, mk(0, 1, 0, 0, 0, 0, 8'd3), "t2_down_3");
    applyStimulus(4'd2, mk(0, 1, 0, 0, 0, 0, 8'd2), "t2_down_2");

    // Down from zero.
    doReset(4'd0, "t3");
    applyStimulus(4'd15, mk(0, 1, 1, 0, 1, 0, 8'd255), "t3_wrap_down");
    applyStimulus(4'd14, mk(0, 1, 0, 0, 0, 0, 8'd254), "t3_down_14");

    // Hold.
    doReset(4'd9, "t4");
    for (int i = 0; i < 5; i++)
      applyStimulus(4'd9, mk(1, 0, 0, 0, 0, 0, 8'd9), $sformatf("t4_hold_%0d", i));

    // Illegal jump then legal steps.
    doReset(4'd3, "t5");
    applyStimulus(4'd7, mk(1, 0, 0, 0, 0, 1, 8'd7), "t5_jump");
    applyStimulus(4'd8, mk(1, 1, 0, 0, 0, STICKY, 8'd8), "t5_step_8");
    applyStimulus(4'd9, mk(1, 1, 0, 0, 0, STICKY, 8'd9), "t5_step_9");

    // Mid-count reset reloads pos from the bus.
    doReset(4'd0, "t6a");
    for (int i = 1; i <= 12; i++)
      applyStimulus(4'(i), mk(1, 1, 0, 0, 0, 0, 8'(i)), $sformatf("t6_up_%0d", i));
    doReset(4'd6, "t6b");
    applyStimulus(4'd7, mk(1, 1, 0, 0, 0, 0, 8'd7), "t6_up_7");

    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
